// File: rtl/mem_pkg.sv
// Shared types, encodings and lane helpers for data_mem_unit and its RAM.
package mem_pkg;

  localparam int B_WORD = 32;

  localparam logic [1:0] MW_WORD = 2'b00;
  localparam logic [1:0] MW_HALF = 2'b01;
  localparam logic [1:0] MW_BYTE = 2'b10;
  localparam logic [1:0] MW_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } mem_state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        width;
    logic              sign;
    logic [B_WORD-1:0] adrs;
    logic [B_WORD-1:0] wdata;
  } mem_req_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] lo);
    logic [3:0] m;
    case (width)
      MW_WORD: m = 4'b1111;
      MW_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      MW_BYTE: m = 4'b0001 << lo;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [B_WORD-1:0] load_extract(input logic [B_WORD-1:0] word,
                                                     input logic [1:0]        width,
                                                     input logic [1:0]        lo,
                                                     input logic              sign);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [B_WORD-1:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (width)
      MW_WORD: r = word;
      MW_HALF: r = {{16{sign & h[15]}}, h};
      MW_BYTE: r = {{24{sign & b[7]}}, b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM: one byte-enabled synchronous write port, combinational
// data and fetch read ports, optional synchronous clear on reset.
module byte_lane_ram #(
  parameter int N_WORDS   = 1024,
  parameter int INIT_ZERO = 1,
  localparam int AW       = $clog2(N_WORDS)
) (
  input  logic          clk_cpu,
  input  logic          reset,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [AW-1:0] faddr,
  output logic [31:0]   fdata
);

  logic [31:0] words [N_WORDS];

  // Each word owns its own register so the clear and the byte writes stay
  // in a single process per storage element.
  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
    logic [31:0] word_q;

    always_ff @(posedge clk_cpu) begin
      if (reset) begin
        if (INIT_ZERO != 0) word_q <= '0;
      end else if (waddr == AW'(gi)) begin
        for (int l = 0; l < 4; l++) begin
          if (be[l]) word_q[8*l +: 8] <= wdata[8*l +: 8];
        end
      end
    end

    assign words[gi] = word_q;
  end

  assign rdata = words[raddr];
  assign fdata = words[faddr];

endmodule

// File: rtl/data_mem_unit.sv
// Handshaked byte/half/word data memory with wait states and a fetch port.
// Optional misalignment trap: define DATA_MEM_MISALIGN_TRAP_EN.
//
// state  | meaning
// S_IDLE | ready = 1, accepting a request
// S_WAIT | wait-state down-counter running toward terminal count 1
// S_RESP | ack = 1, rdata/fault valid
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int N_WORDS     = 1024,
  parameter int WAIT_STATES = 0,
  parameter int INIT_ZERO   = 1
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic [B_WORD-1:0] pc,
  output logic [B_WORD-1:0] inst,
  input  logic              req,
  output logic              ready,
  input  logic              we,
  input  logic [1:0]        width,
  input  logic              sign,
  input  logic [B_WORD-1:0] adrs,
  input  logic [B_WORD-1:0] wdata,
  output logic              ack,
  output logic [B_WORD-1:0] rdata,
  output logic              fault
);

  localparam int         AW = $clog2(N_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q;
  mem_req_t          lat_req, live_req, cur_req;
  logic              accept, commit;
  logic [1:0]        lo_raw, lo_eff;
  logic              flt;
  logic [3:0]        be;
  logic [B_WORD-1:0] wdata_lanes;
  logic [B_WORD-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign ready  = (state_q == S_IDLE);
  assign ack    = (state_q == S_RESP);
  assign accept = req && ready;

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= WS;
      end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign live_req = '{we: we, width: width, sign: sign, adrs: adrs, wdata: wdata};

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      lat_req <= '0;
    end else if (accept) begin
      lat_req <= live_req;
    end
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // live inputs are used before they have been latched.
  assign cur_req = ready ? live_req : lat_req;
  assign lo_raw  = cur_req.adrs[1:0];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (cur_req.width == MW_HALF && lo_raw[0]) ||
                    (cur_req.width == MW_WORD && lo_raw != 2'b00);
  assign flt      = (cur_req.width == MW_RSVD) || misalign;
  assign lo_eff   = lo_raw;
`else
  assign flt = (cur_req.width == MW_RSVD);
  always_comb begin
    lo_eff = lo_raw;
    case (cur_req.width)
      MW_WORD: lo_eff = 2'b00;
      MW_HALF: lo_eff = {lo_raw[1], 1'b0};
      default: lo_eff = lo_raw;
    endcase
  end
`endif

  always_comb begin
    wdata_lanes = cur_req.wdata;
    case (cur_req.width)
      MW_BYTE: wdata_lanes = {4{cur_req.wdata[7:0]}};
      MW_HALF: wdata_lanes = {2{cur_req.wdata[15:0]}};
      default: wdata_lanes = cur_req.wdata;
    endcase
  end

  assign be = (commit && !reset && cur_req.we && !flt) ? lane_mask(cur_req.width, lo_eff) : 4'b0000;

  byte_lane_ram #(
    .N_WORDS  (N_WORDS),
    .INIT_ZERO(INIT_ZERO)
  ) u_ram (
    .clk_cpu(clk_cpu),
    .reset  (reset),
    .be     (be),
    .waddr  (cur_req.adrs[AW+1:2]),
    .wdata  (wdata_lanes),
    .raddr  (cur_req.adrs[AW+1:2]),
    .rdata  (ram_rdata),
    .faddr  (pc[AW+1:2]),
    .fdata  (inst)
  );

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      rdata <= '0;
      fault <= 1'b0;
    end else if (commit) begin
      fault <= flt;
      rdata <= (cur_req.we || flt) ? '0 : load_extract(ram_rdata, cur_req.width, lo_eff, cur_req.sign);
    end
  end

  // Addresses wrap modulo the RAM size; the bits above the index are ignored.
  assign unused_addr_bits = ^{pc[B_WORD-1:AW+2], pc[1:0], cur_req.adrs[B_WORD-1:AW+2]};

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: a zero-wait-state instance and a
// three-wait-state instance without reset clear, checked against a byte model.
module tb_data_mem_unit;

  localparam int NW = 64;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk_cpu = 1'b0;
  logic        reset0, reset3, req0, req3, we, sign;
  logic [1:0]  width;
  logic [31:0] pc, adrs, wdata;
  logic [31:0] inst0, inst3, rdata0, rdata3;
  logic        ready0, ready3, ack0, ack3, fault0, fault3;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl [2][NW];

  always #5 clk_cpu = ~clk_cpu;

  data_mem_unit #(.N_WORDS(NW), .WAIT_STATES(0), .INIT_ZERO(1)) dut0 (
    .clk_cpu(clk_cpu), .reset(reset0), .pc(pc), .inst(inst0), .req(req0), .ready(ready0),
    .we(we), .width(width), .sign(sign), .adrs(adrs), .wdata(wdata),
    .ack(ack0), .rdata(rdata0), .fault(fault0));

  data_mem_unit #(.N_WORDS(NW), .WAIT_STATES(3), .INIT_ZERO(0)) dut3 (
    .clk_cpu(clk_cpu), .reset(reset3), .pc(pc), .inst(inst3), .req(req3), .ready(ready3),
    .we(we), .width(width), .sign(sign), .adrs(adrs), .wdata(wdata),
    .ack(ack3), .rdata(rdata3), .fault(fault3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed view of each word, access size in bytes.
  task automatic model_access(input int d, input logic w, input logic [1:0] wd, input logic sg,
                              input logic [31:0] a, input logic [31:0] wdat,
                              output logic [31:0] rd, output logic ft);
    int idx, off, size;
    logic [31:0] word;
    idx = int'((a >> 2) % NW);
    off = int'(a % 4);
    rd  = '0;
    ft  = 1'b0;
    if (wd == 2'b11) begin
      ft = 1'b1;
      return;
    end
    size = (wd == 2'b00) ? 4 : (wd == 2'b01) ? 2 : 1;
    if (off % size != 0) begin
      if (TRAP) begin
        ft = 1'b1;
        return;
      end
      off = off - off % size;
    end
    word = mdl[d][idx];
    if (w) begin
      for (int b = 0; b < size; b++) word[8*(off+b) +: 8] = wdat[8*b +: 8];
      mdl[d][idx] = word;
    end else begin
      for (int b = 0; b < size; b++) rd[8*b +: 8] = word[8*(off+b) +: 8];
      if (sg && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
    end
  endtask

  task automatic do_access(input int d, input logic w, input logic [1:0] wd, input logic sg,
                           input logic [31:0] a, input logic [31:0] wdat,
                           output logic [31:0] rd, output logic ft);
    int          lat;
    logic        ak;
    logic [31:0] exp_rd;
    logic        exp_ft;
    model_access(d, w, wd, sg, a, wdat, exp_rd, exp_ft);
    @(negedge clk_cpu);
    we = w; width = wd; sign = sg; adrs = a; wdata = wdat;
    if (d == 0) req0 = 1'b1; else req3 = 1'b1;
    #1;
    chk("ready_at_req", 32'(d == 0 ? ready0 : ready3), 32'd1);
    @(negedge clk_cpu);
    req0 = 1'b0; req3 = 1'b0;
    we = 1'($urandom); width = 2'($urandom); sign = 1'($urandom);
    adrs = $urandom; wdata = $urandom;
    lat = 1;
    ak  = (d == 0) ? ack0 : ack3;
    while (!ak && lat < 40) begin
      @(negedge clk_cpu);
      lat++;
      ak = (d == 0) ? ack0 : ack3;
    end
    chk("ack_latency", 32'(lat), 32'((d == 0) ? 1 : 4));
    rd = (d == 0) ? rdata0 : rdata3;
    ft = (d == 0) ? fault0 : fault3;
    chk("rdata_vs_model", rd, exp_rd);
    chk("fault_vs_model", 32'(ft), 32'(exp_ft));
    pc = {a[31:2], 2'b00};
    #1;
    chk("inst_vs_model", (d == 0) ? inst0 : inst3, mdl[d][int'((a >> 2) % NW)]);
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  wd;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic        exp_ft;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic w, input logic [1:0] wd, input logic sg,
                              input logic [31:0] a, input logic [31:0] wdat,
                              input logic [31:0] er, input logic ef);
    vec_t v;
    v.name = n; v.w = w; v.wd = wd; v.sg = sg; v.a = a; v.wdat = wdat; v.exp_rd = er; v.exp_ft = ef;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ft;
    logic        saw_ack;

    reset0 = 1'b1; reset3 = 1'b1; req0 = 1'b0; req3 = 1'b0;
    we = 1'b0; width = 2'b00; sign = 1'b0; adrs = '0; wdata = '0; pc = 32'h10;
    for (int d = 0; d < 2; d++) for (int i = 0; i < NW; i++) mdl[d][i] = '0;

    repeat (3) @(negedge clk_cpu);
    #1;
    chk("reset_ready", 32'(ready0), 32'd1);
    chk("reset_ack", 32'(ack0), 32'd0);
    chk("reset_fault", 32'(fault0), 32'd0);
    chk("reset_rdata", rdata0, 32'd0);
    chk("reset_inst_zero", inst0, 32'd0);
    chk("reset_ready_ws3", 32'(ready3), 32'd1);
    reset0 = 1'b0; reset3 = 1'b0;

    // Give the non-clearing instance known contents.
    for (int i = 0; i < NW; i++) do_access(1, 1'b1, 2'b00, 1'b0, 32'(i * 4), 32'd0, rd, ft);

    add("st_w10",   1, 2'b00, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add("ld_w10",   0, 2'b00, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add("clr_w10",  1, 2'b00, 0, 32'h10,  32'h0,        32'h0,        0);
    add("st_b13",   1, 2'b10, 0, 32'h13,  32'h80,       32'h0,        0);
    add("ld_w10b",  0, 2'b00, 0, 32'h10,  32'h0,        32'h80000000, 0);
    add("ld_b13s",  0, 2'b10, 1, 32'h13,  32'h0,        32'hFFFFFF80, 0);
    add("ld_b13u",  0, 2'b10, 0, 32'h13,  32'h0,        32'h00000080, 0);
    add("st_h22",   1, 2'b01, 0, 32'h22,  32'h8001,     32'h0,        0);
    add("ld_h22s",  0, 2'b01, 1, 32'h22,  32'h0,        32'hFFFF8001, 0);
    add("ld_h20u",  0, 2'b01, 0, 32'h20,  32'h0,        32'h00000000, 0);
    add("ld_h22u",  0, 2'b01, 0, 32'h22,  32'h0,        32'h00008001, 0);
    add("st_w04",   1, 2'b00, 0, 32'h04,  32'h11223344, 32'h0,        0);
    add("st_w06",   1, 2'b00, 0, 32'h06,  32'hAABBCCDD, 32'h0,        TRAP);
    add("ld_w04",   0, 2'b00, 0, 32'h04,  32'h0,        TRAP ? 32'h11223344 : 32'hAABBCCDD, 0);
    add("ld_w06",   0, 2'b00, 0, 32'h06,  32'h0,        TRAP ? 32'h0 : 32'hAABBCCDD, TRAP);
    add("ld_h05",   0, 2'b01, 0, 32'h05,  32'h0,        TRAP ? 32'h0 : 32'h0000CCDD, TRAP);
    add("ld_rsvd",  0, 2'b11, 0, 32'h08,  32'h0,        32'h0,        1);
    add("st_rsvd",  1, 2'b11, 0, 32'h08,  32'hFFFFFFFF, 32'h0,        1);
    add("ld_w08",   0, 2'b00, 0, 32'h08,  32'h0,        32'h0,        0);
    add("st_alias", 1, 2'b00, 0, 32'h100, 32'h5A5A5A5A, 32'h0,        0);
    add("ld_w00",   0, 2'b00, 0, 32'h00,  32'h0,        32'h5A5A5A5A, 0);

    foreach (vecs[i]) begin
      do_access(0, vecs[i].w, vecs[i].wd, vecs[i].sg, vecs[i].a, vecs[i].wdat, rd, ft);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_fault"}, 32'(ft), 32'(vecs[i].exp_ft));
    end

    // Three wait states: busy window, and a req pulse during WAIT is dropped.
    model_access(1, 1'b1, 2'b00, 1'b0, 32'h10, 32'hCAFEF00D, rd, ft);
    @(negedge clk_cpu);
    we = 1'b1; width = 2'b00; sign = 1'b0; adrs = 32'h10; wdata = 32'hCAFEF00D; req3 = 1'b1;
    @(negedge clk_cpu);
    req3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("ws3_ready_k%0d", k), 32'(ready3), 32'(k == 5));
      chk($sformatf("ws3_ack_k%0d", k), 32'(ack3), 32'(k == 4));
      if (k == 2) begin
        req3 = 1'b1; we = 1'b1; width = 2'b00; adrs = 32'h20; wdata = 32'h1;
      end
      if (k == 3) req3 = 1'b0;
      @(negedge clk_cpu);
    end
    do_access(1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, ft);
    chk("ws3_dropped_req", rd, 32'h0);
    do_access(1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, ft);
    chk("ws3_ld_w10", rd, 32'hCAFEF00D);

    // Reset on the commit edge of a store: aborted, no ack, word unchanged.
    @(negedge clk_cpu);
    we = 1'b1; width = 2'b00; sign = 1'b0; adrs = 32'h10; wdata = 32'h12345678; req3 = 1'b1;
    @(negedge clk_cpu);
    req3 = 1'b0;
    repeat (2) @(negedge clk_cpu);
    reset3 = 1'b1;
    @(negedge clk_cpu);
    reset3 = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(ready3), 32'd1);
    chk("rst_wait_rdata", rdata3, 32'd0);
    saw_ack = ack3;
    repeat (5) begin
      @(negedge clk_cpu);
      saw_ack = saw_ack | ack3;
    end
    chk("rst_wait_no_ack", 32'(saw_ack), 32'd0);
    do_access(1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, ft);
    chk("rst_wait_word_kept", rd, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      int          d;
      logic [1:0]  wd;
      d  = int'($urandom_range(0, 1));
      wd = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_access(d, 1'($urandom), wd, 1'($urandom), $urandom, $urandom, rd, ft);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
